// File: rtl/vote_pkg.sv
// Shared state encoding and default timing parameters for the vote sampler.
package vote_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_WINDOW_CYCLES   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Width of a counter able to hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vote_sampler_btn_debounce.sv
// Single-bit debouncer: the accepted level follows the raw input only after
// it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
    import vote_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (raw == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= raw;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vote_sampler.sv
// Debounced three-voter sampler collecting sticky votes over a fixed window.
// Define VOTE_SAMPLER_SYNC_EN to add a 2-flop synchronizer ahead of each debouncer.
module vote_sampler
    import vote_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned WINDOW_CYCLES   = DEF_WINDOW_CYCLES
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] btn,
    input  logic       start,
    output logic [2:0] abc,
    output logic       abc_valid,
    output logic       busy,
    output logic [7:0] round_cnt
);

    localparam int unsigned WW = cnt_width(WINDOW_CYCLES);

    logic [2:0]    btn_in;
    logic [2:0]    db;
    logic [2:0]    vote;
    logic [WW-1:0] win_cnt;
    state_t        state;

`ifdef VOTE_SAMPLER_SYNC_EN
    logic [2:0] sync1;
    logic [2:0] sync2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    assign btn_in = sync2;
`else
    assign btn_in = btn;
`endif

    for (genvar i = 0; i < 3; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .resetn(resetn),
            .raw   (btn_in[i]),
            .level (db[i])
        );
    end

    // Outputs are updated on the transition into DONE so they are valid
    // exactly while the FSM sits in DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            vote      <= '0;
            win_cnt   <= '0;
            abc       <= '0;
            abc_valid <= 1'b0;
            busy      <= 1'b0;
            round_cnt <= '0;
        end else begin
            abc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= COLLECT;
                        vote    <= '0;
                        win_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                COLLECT: begin
                    vote <= vote | db;
                    if (win_cnt == WW'(WINDOW_CYCLES - 1)) begin
                        state     <= DONE;
                        abc       <= vote | db;
                        abc_valid <= 1'b1;
                        round_cnt <= round_cnt + 8'd1;
                    end else begin
                        win_cnt <= win_cnt + WW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vote_sampler.sv
// Testbench for vote_sampler: directed rounds plus random button traffic,
// checked every cycle against a window-based behavioural model.
module tb_vote_sampler;

    localparam int DB = 4;
    localparam int W  = 16;
    localparam int PERIOD = W + 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [2:0] btn = 3'b000;
    logic [2:0] abc;
    logic       abc_valid;
    logic       busy;
    logic [7:0] round_cnt;

    vote_sampler #(
        .DEBOUNCE_CYCLES(DB),
        .WINDOW_CYCLES  (W)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .btn      (btn),
        .start    (start),
        .abc      (abc),
        .abc_valid(abc_valid),
        .busy     (busy),
        .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a level is accepted once the last DB samples all agree
    // and differ from it; a round is a position counter over the window.
    logic [2:0] m_pipe[$];
    logic [2:0] m_hist[$];
    logic [2:0] m_db;
    logic [2:0] m_votes;
    logic [2:0] m_abc;
    logic [7:0] m_rounds;
    int         m_pos;

    logic [2:0] pulses[$];
    int         pulse_at[$];
    int         tick_no = 0;

    function automatic void model_reset();
        m_pipe = {3'b000, 3'b000};
        m_hist = {};
        for (int j = 0; j < DB; j++) m_hist.push_back(3'b000);
        m_db     = '0;
        m_votes  = '0;
        m_abc    = '0;
        m_rounds = '0;
        m_pos    = -1;
    endfunction

    function automatic void model_edge(input logic [2:0] b, input logic s);
        logic [2:0] din;
        bit         agree;
        if (m_pos < 0) begin
            if (s) begin
                m_pos   = 0;
                m_votes = '0;
            end
        end else if (m_pos < W) begin
            m_votes = m_votes | m_db;
            m_pos++;
            if (m_pos == W) begin
                m_abc = m_votes;
                m_rounds++;
            end
        end else begin
            m_pos = -1;
        end
`ifdef VOTE_SAMPLER_SYNC_EN
        m_pipe.push_back(b);
        din = m_pipe.pop_front();
`else
        din = b;
`endif
        m_hist.push_back(din);
        void'(m_hist.pop_front());
        for (int i = 0; i < 3; i++) begin
            agree = 1'b1;
            foreach (m_hist[j]) if (m_hist[j][i] != din[i]) agree = 1'b0;
            if (agree) m_db[i] = din[i];
        end
    endfunction

    task automatic tick(input logic [2:0] b, input logic s);
        btn   = b;
        start = s;
        @(posedge clk);
        model_edge(b, s);
        tick_no++;
        #1;
        check("abc", abc, m_abc);
        check("abc_valid", abc_valid, m_pos == W);
        check("busy", busy, m_pos >= 0);
        check("round_cnt", round_cnt, m_rounds);
        if (abc_valid) begin
            pulses.push_back(abc);
            pulse_at.push_back(tick_no);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        btn    = 3'b000;
        start  = 1'b0;
        #2;
        model_reset();
        check("rst_abc", abc, 0);
        check("rst_abc_valid", abc_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_round_cnt", round_cnt, 0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic settle();
        for (int k = 0; k < 8; k++) tick(3'b000, 1'b0);
    endtask

    initial begin
        int         n_before;
        logic [2:0] b;

        model_reset();
        do_reset();

        // Clean press of A and B from window cycle 2.
        tick(3'b000, 1'b1);
        for (int k = 1; k <= W; k++) tick((k >= 2) ? 3'b110 : 3'b000, 1'b0);
        check("s1_abc", abc, 3'b110);
        check("s1_valid", abc_valid, 1);
        check("s1_round_cnt", round_cnt, 1);
        tick(3'b110, 1'b0);
        check("s1_pulses", pulses.size(), 1);
        settle();

        // C bouncing every 2 cycles never becomes a vote.
        tick(3'b000, 1'b1);
        for (int k = 1; k <= W; k++) tick(((k / 2) % 2 == 1) ? 3'b001 : 3'b000, 1'b0);
        check("s2_abc", abc, 3'b000);
        check("s2_valid", abc_valid, 1);
        tick(3'b000, 1'b0);
        settle();

        // Short A press early in the window stays latched.
        tick(3'b000, 1'b1);
        for (int k = 1; k <= W; k++) tick((k >= 2 && k < 8) ? 3'b100 : 3'b000, 1'b0);
        check("s3_abc", abc, 3'b100);
        tick(3'b000, 1'b0);
        settle();

        // C pressed 5 cycles before window end: only the unsynchronised build counts it.
        tick(3'b000, 1'b1);
        for (int k = 1; k <= W; k++) tick((k >= 12) ? 3'b001 : 3'b000, 1'b0);
`ifdef VOTE_SAMPLER_SYNC_EN
        check("s4_late_abc", abc, 3'b000);
`else
        check("s4_late_abc", abc, 3'b001);
`endif
        tick(3'b001, 1'b0);
        settle();
        check("s4_pulses", pulses.size(), 4);

        // Back-to-back rounds with start held high; B and C only in round 2.
        n_before = pulses.size();
        for (int t = 0; t < 3 * PERIOD; t++) begin
            b = (t >= PERIOD + 1 && t <= PERIOD + 10) ? 3'b011 : 3'b000;
            tick(b, (t < 3 * PERIOD - 1) ? 1'b1 : 1'b0);
        end
        check("s5_pulses", pulses.size(), n_before + 3);
        if (pulses.size() == n_before + 3) begin
            check("s5_r1", pulses[n_before], 3'b000);
            check("s5_r2", pulses[n_before + 1], 3'b011);
            check("s5_r3", pulses[n_before + 2], 3'b000);
            check("s5_gap12", pulse_at[n_before + 1] - pulse_at[n_before], PERIOD);
            check("s5_gap23", pulse_at[n_before + 2] - pulse_at[n_before + 1], PERIOD);
        end
        check("s5_round_cnt", round_cnt, 7);
        check("s5_idle", busy, 0);

        // Reset at window cycle 10 aborts the round.
        tick(3'b000, 1'b1);
        for (int k = 1; k <= 10; k++) tick(3'b111, 1'b0);
        do_reset();
        check("s6_no_pulse", pulses.size(), 7);
        tick(3'b000, 1'b1);
        for (int k = 1; k <= W; k++) tick(3'b000, 1'b0);
        check("s6_abc", abc, 3'b000);
        check("s6_round_cnt", round_cnt, 1);
        tick(3'b000, 1'b0);

        // 256 back-to-back rounds with random button traffic: counter wraps.
        do_reset();
        n_before = pulses.size();
        b = 3'b000;
        for (int t = 0; t < 256 * PERIOD; t++) begin
            if ($urandom_range(0, 5) == 0) b = 3'($urandom_range(0, 7));
            tick(b, (t < 256 * PERIOD - 1) ? 1'b1 : 1'b0);
        end
        check("s7_pulses", pulses.size(), n_before + 256);
        check("s7_round_cnt", round_cnt, 0);
        check("s7_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
